// File: rtl/srsystem_tx.sv
`default_nettype none
// ============================================================================
// srsystem_tx -- serial frame transmitter: start, 8 data bits MSB-first,
// parity, stop, with an optional idle gap between frames.  Rev 1.0
// ============================================================================
module srsystem_tx #(
    parameter int PAR_ODD = 1,
    parameter int GAP     = 0
) (
    input  logic       txclk,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] din,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       lost
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic       PAR_SENSE = (PAR_ODD != 0);
    localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, bit_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic [9:0] sh, sh_nxt;
    logic       tx_nxt, busy_nxt, done_nxt, lost_nxt;
    logic       can_load;
    logic       par;

    assign par = (^din) ^ PAR_SENSE;

    always_ff @(posedge txclk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            gap_cnt <= 4'd0;
            sh      <= 10'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            lost    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_nxt;
            gap_cnt <= gap_nxt;
            sh      <= sh_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            lost    <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        sh_nxt    = sh;
        tx_nxt    = tx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        lost_nxt  = 1'b0;
        can_load  = 1'b0;

        case (state)
            ST_IDLE: begin
                can_load = 1'b1;
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
            end
            ST_SHIFT: begin
                if (bit_cnt == 4'd10) begin
                    tx_nxt   = 1'b1;
                    done_nxt = 1'b1;
                    if (GAP == 0) begin
                        // stop-bit edge doubles as an accept edge for back-to-back frames
                        can_load  = 1'b1;
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_LOAD;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    tx_nxt  = sh[9];
                    sh_nxt  = {sh[8:0], 1'b1};
                    bit_nxt = bit_cnt + 4'd1;
                end
            end
            ST_GAP: begin
                tx_nxt = 1'b1;
                if (gap_cnt == 4'd0) begin
                    can_load  = 1'b1;
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    gap_nxt = gap_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        if (ld) begin
            if (can_load) begin
                state_nxt = ST_SHIFT;
                bit_nxt   = 4'd0;
                sh_nxt    = {din, par, 1'b1};
                tx_nxt    = 1'b0;
                busy_nxt  = 1'b1;
            end else begin
                lost_nxt = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_srsystem_tx.sv
`default_nettype none
// tb_srsystem_tx -- directed table plus hand-written sequences for srsystem_tx.
module tb_srsystem_tx;

    logic       txclk;
    logic       clr;
    logic       ld;
    logic [7:0] din;
    logic       tx,   busy,   done,   lost;
    logic       tx_e, busy_e, done_e, lost_e;
    logic       tx_g, busy_g, done_g, lost_g;

    int n_vec = 0;
    int n_err = 0;

    srsystem_tx #(.PAR_ODD(1), .GAP(0)) dut (
        .txclk(txclk), .clr(clr), .ld(ld), .din(din),
        .tx(tx), .busy(busy), .done(done), .lost(lost)
    );
    srsystem_tx #(.PAR_ODD(0), .GAP(0)) dut_e (
        .txclk(txclk), .clr(clr), .ld(ld), .din(din),
        .tx(tx_e), .busy(busy_e), .done(done_e), .lost(lost_e)
    );
    srsystem_tx #(.PAR_ODD(1), .GAP(3)) dut_g (
        .txclk(txclk), .clr(clr), .ld(ld), .din(din),
        .tx(tx_g), .busy(busy_g), .done(done_g), .lost(lost_g)
    );

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic       ld;
        logic [7:0] din;
        logic       tx;
        logic       tx_e;
        logic       busy;
        logic       done;
        logic       lost;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic do_reset();
        ld  = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        clr = 1'b1;
    endtask

    // Sends one word on the GAP=0 instances and captures the 11 line bits of both
    task automatic send_rx(input logic [7:0] w, output logic [10:0] f, output logic [10:0] fe);
        ld  = 1'b1;
        din = w;
        tick();
        f[10]  = tx;
        fe[10] = tx_e;
        ld  = 1'b0;
        din = ~w;
        for (int k = 9; k >= 0; k--) begin
            tick();
            f[k]  = tx;
            fe[k] = tx_e;
        end
        tick();
        check("rx_done", {15'd0, done}, 16'd1);
        check("rx_idle_tx", {15'd0, tx}, 16'd1);
    endtask

    task automatic rx_check(input logic [7:0] w, input logic [10:0] f, input logic odd);
        check("rx_start", {15'd0, f[10]}, 16'd0);
        check("rx_data", {8'd0, f[9:2]}, {8'd0, w});
        check("rx_parity", {15'd0, ^f[9:1]}, {15'd0, odd});
        check("rx_stop", {15'd0, f[0]}, 16'd1);
    endtask

    initial begin
        logic [10:0] f, fe;
        logic [21:0] b2b;
        logic        bad;
        logic [7:0]  w;

        //                ld  din    tx tx_e busy done lost
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset state
        clr = 1'b0;
        ld  = 1'b0;
        din = 8'h00;
        tick();
        tick();
        check("rst_tx",   {15'd0, tx},   16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_lost", {15'd0, lost}, 16'd0);
        clr = 1'b1;
        tick();

        // A5 frame, with a rejected load and din change at cycle 5
        for (int i = 0; i < 14; i++) begin
            ld  = tbl[i].ld;
            din = tbl[i].din;
            tick();
            check($sformatf("tbl%0d_tx", i),   {15'd0, tx},   {15'd0, tbl[i].tx});
            check($sformatf("tbl%0d_tx_e", i), {15'd0, tx_e}, {15'd0, tbl[i].tx_e});
            check($sformatf("tbl%0d_busy", i), {15'd0, busy}, {15'd0, tbl[i].busy});
            check($sformatf("tbl%0d_done", i), {15'd0, done}, {15'd0, tbl[i].done});
            check($sformatf("tbl%0d_lost", i), {15'd0, lost}, {15'd0, tbl[i].lost});
        end

        // parity bit values
        send_rx(8'h01, f, fe);
        check("par_01_odd", {15'd0, f[1]}, 16'd0);
        send_rx(8'hFF, f, fe);
        check("par_FF_odd", {15'd0, f[1]}, 16'd1);
        send_rx(8'hA5, f, fe);
        check("par_A5_even", {15'd0, fe[1]}, 16'd0);

        // ld held high: two contiguous frames
        do_reset();
        ld  = 1'b1;
        din = 8'h3C;
        for (int k = 0; k < 22; k++) begin
            tick();
            b2b[21-k] = tx;
            if (k == 5)  din = 8'hC3;
            if (k == 10) check("b2b_done10", {15'd0, done}, 16'd0);
            if (k == 11) begin
                check("b2b_done11", {15'd0, done}, 16'd1);
                check("b2b_busy11", {15'd0, busy}, 16'd1);
            end
            if (k == 21) ld = 1'b0;
        end
        tick();
        check("b2b_done22", {15'd0, done}, 16'd1);
        check("b2b_busy22", {15'd0, busy}, 16'd0);
        check("b2b_frame1", {5'd0, b2b[21:11]}, {5'd0, 11'b0_00111100_1_1});
        check("b2b_frame2", {5'd0, b2b[10:0]},  {5'd0, 11'b0_11000011_1_1});

        // GAP=3: loads during the gap are rejected, start waits for the gap end
        do_reset();
        ld  = 1'b1;
        din = 8'h96;
        tick();
        ld = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        tick();
        check("gap_done11", {15'd0, done_g}, 16'd1);
        check("gap_busy11", {15'd0, busy_g}, 16'd1);
        ld  = 1'b1;
        din = 8'hFF;
        tick();
        check("gap_lost12", {15'd0, lost_g}, 16'd1);
        check("gap_tx12",   {15'd0, tx_g},   16'd1);
        check("gap_busy12", {15'd0, busy_g}, 16'd1);
        tick();
        check("gap_lost13", {15'd0, lost_g}, 16'd1);
        check("gap_tx13",   {15'd0, tx_g},   16'd1);
        tick();
        check("gap_start14", {15'd0, tx_g},   16'd0);
        check("gap_lost14",  {15'd0, lost_g}, 16'd0);
        check("gap_busy14",  {15'd0, busy_g}, 16'd1);
        ld = 1'b0;
        f[10] = tx_g;
        for (int k = 9; k >= 0; k--) begin
            tick();
            f[k] = tx_g;
        end
        rx_check(8'hFF, f, 1'b1);

        // reset during cycle 6 of a frame
        do_reset();
        ld  = 1'b1;
        din = 8'hF0;
        tick();
        ld = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("abort_pre_tx",   {15'd0, tx},   16'd0);
        check("abort_pre_busy", {15'd0, busy}, 16'd1);
        #2;
        clr = 1'b0;
        #1;
        check("abort_tx",   {15'd0, tx},   16'd1);
        check("abort_busy", {15'd0, busy}, 16'd0);
        tick();
        tick();
        clr = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        check("abort_no_resume", {15'd0, bad}, 16'd0);
        send_rx(8'h5A, f, fe);
        check("abort_5A_frame", {5'd0, f}, {5'd0, 11'b0_01011010_1_1});

        // loopback receiver over random words
        for (int n = 0; n < 256; n++) begin
            w = 8'($urandom_range(0, 255));
            send_rx(w, f, fe);
            rx_check(w, f, 1'b1);
            check("rx_even_parity", {15'd0, ^fe[9:1]}, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
